imem_program_ctrl: RTL and testbench

Programming controller for the byte-addressed, big-endian instruction memory. It has two modes. In normal run mode it passes the processor PC through as the fetch address. In program mode it stalls the processor, accepts 32-bit program words over a valid/ready stream and writes each word into instruction memory one byte per cycle. Once loading finishes it issues a one-cycle processor reset so execution restarts cleanly on the new program. It sits between the PC register, the instruction memory and the boot/debug host.

---
 rtl/imem_program_ctrl.sv | 143 ++++++++++++++
 tb/tb_imem_program_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_ctrl.sv
// Instruction-memory programming controller: passes the PC through in run mode,
// and in program mode streams 32-bit words into memory big-endian, one byte per cycle.
module imem_program_ctrl #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              prog_start_i,
  input  logic              prog_valid_i,
  output logic              prog_ready_o,
  input  logic [31:0]       prog_data_i,
  input  logic              prog_last_i,
  input  logic [31:0]       pc_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              mem_we_o,
  output logic              cpu_stall_o,
  output logic              cpu_reset_o,
  output logic [ADDR_W-2:0] words_loaded_o,
  output logic              overflow_o
);

  localparam int unsigned WPTR_W = ADDR_W + 1;
  localparam int unsigned CNT_W  = ADDR_W - 1;
  // Highest word-aligned address that still leaves room for a full word.
  localparam logic [WPTR_W-1:0] LAST_WORD_ADDR = WPTR_W'((1 << ADDR_W) - 4);
  localparam logic [WPTR_W-1:0] BASE_PTR       = WPTR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_WAIT_WORD = 2'd1,
    S_WRITE     = 2'd2,
    S_FLUSH     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WPTR_W-1:0]  wptr_q, wptr_d;
  logic [1:0]         bsel_q, bsel_d;
  logic [31:0]        word_q, word_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   words_loaded_q, words_loaded_d;
  logic               overflow_q, overflow_d;

  // Upper PC bits are outside the memory's address range.
  logic unused_pc;
  assign unused_pc = ^pc_i[31:ADDR_W];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= S_RUN;
      wptr_q         <= BASE_PTR;
      bsel_q         <= 2'd0;
      word_q         <= 32'd0;
      last_q         <= 1'b0;
      words_loaded_q <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      wptr_q         <= wptr_d;
      bsel_q         <= bsel_d;
      word_q         <= word_d;
      last_q         <= last_d;
      words_loaded_q <= words_loaded_d;
      overflow_q     <= overflow_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wptr_d         = wptr_q;
    bsel_d         = bsel_q;
    word_d         = word_q;
    last_d         = last_q;
    words_loaded_d = words_loaded_q;
    overflow_d     = overflow_q;
    prog_ready_o   = 1'b0;
    mem_addr_o     = wptr_q[ADDR_W-1:0];
    mem_we_o       = 1'b0;
    cpu_stall_o    = 1'b1;
    cpu_reset_o    = 1'b0;

    unique case (state_q)
      S_RUN: begin
        mem_addr_o  = pc_i[ADDR_W-1:0];
        cpu_stall_o = 1'b0;
        if (prog_start_i) begin
          state_d        = S_WAIT_WORD;
          wptr_d         = BASE_PTR;
          words_loaded_d = '0;
          overflow_d     = 1'b0;
        end
      end
      S_WAIT_WORD: begin
        prog_ready_o = 1'b1;
        if (prog_valid_i) begin
          if (wptr_q <= LAST_WORD_ADDR) begin
            word_d  = prog_data_i;
            last_d  = prog_last_i;
            bsel_d  = 2'd0;
            state_d = S_WRITE;
          end else begin
            // Memory full: the word is consumed but never written.
            overflow_d = 1'b1;
            if (prog_last_i) begin
              state_d = S_FLUSH;
            end
          end
        end
      end
      S_WRITE: begin
        mem_we_o = 1'b1;
        wptr_d   = wptr_q + WPTR_W'(1);
        bsel_d   = bsel_q + 2'd1;
        if (bsel_q == 2'd3) begin
          words_loaded_d = words_loaded_q + CNT_W'(1);
          state_d        = last_q ? S_FLUSH : S_WAIT_WORD;
        end
      end
      S_FLUSH: begin
        cpu_reset_o = 1'b1;
        state_d     = S_RUN;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // Byte 0 of a word is bits 31:24 (big-endian).
  always_comb begin
    unique case (bsel_q)
      2'd0:    mem_wdata_o = word_q[31:24];
      2'd1:    mem_wdata_o = word_q[23:16];
      2'd2:    mem_wdata_o = word_q[15:8];
      default: mem_wdata_o = word_q[7:0];
    endcase
  end

  assign words_loaded_o = words_loaded_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_imem_program_ctrl.sv
// Bench for imem_program_ctrl: a 4 KiB instance and a 16-byte instance, with a
// byte-write scoreboard fed by a reference pointer model.
module tb_imem_program_ctrl;

  localparam int unsigned AW_B = 12;
  localparam int unsigned AW_S = 4;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, prog_start, prog_valid, prog_last, sel_small;
  logic [31:0] prog_data, pc;

  logic            b_ready, b_we, b_stall, b_creset, b_ovf;
  logic [AW_B-1:0] b_addr;
  logic [7:0]      b_wdata;
  logic [AW_B-2:0] b_words;
  logic            s_ready, s_we, s_stall, s_creset, s_ovf;
  logic [AW_S-1:0] s_addr;
  logic [7:0]      s_wdata;
  logic [AW_S-2:0] s_words;

  imem_program_ctrl #(.ADDR_W(AW_B), .BASE_ADDR(0)) u_big (
    .clk_i(clk), .reset_i(reset),
    .prog_start_i(prog_start & ~sel_small), .prog_valid_i(prog_valid & ~sel_small),
    .prog_ready_o(b_ready), .prog_data_i(prog_data), .prog_last_i(prog_last),
    .pc_i(pc), .mem_addr_o(b_addr), .mem_wdata_o(b_wdata), .mem_we_o(b_we),
    .cpu_stall_o(b_stall), .cpu_reset_o(b_creset), .words_loaded_o(b_words),
    .overflow_o(b_ovf)
  );

  imem_program_ctrl #(.ADDR_W(AW_S), .BASE_ADDR(0)) u_small (
    .clk_i(clk), .reset_i(reset),
    .prog_start_i(prog_start & sel_small), .prog_valid_i(prog_valid & sel_small),
    .prog_ready_o(s_ready), .prog_data_i(prog_data), .prog_last_i(prog_last),
    .pc_i(pc), .mem_addr_o(s_addr), .mem_wdata_o(s_wdata), .mem_we_o(s_we),
    .cpu_stall_o(s_stall), .cpu_reset_o(s_creset), .words_loaded_o(s_words),
    .overflow_o(s_ovf)
  );

  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t exp_b[$];
  wr_t exp_s[$];
  int  mw_b, mw_s, creset_b, creset_s;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Every observed byte write must match the oldest expected one.
  always @(negedge clk) begin
    wr_t e;
    if (b_we) begin
      if (exp_b.size() == 0) check("big_unexpected_write", {20'd0, b_addr}, 32'hFFFF_FFFF);
      else begin
        e = exp_b.pop_front();
        check("big_addr", 32'(b_addr), 32'(e.addr));
        check("big_wdata", 32'(b_wdata), 32'(e.data));
      end
    end
    if (s_we) begin
      if (exp_s.size() == 0) check("small_unexpected_write", {28'd0, s_addr}, 32'hFFFF_FFFF);
      else begin
        e = exp_s.pop_front();
        check("small_addr", 32'(s_addr), 32'(e.addr));
        check("small_wdata", 32'(s_wdata), 32'(e.data));
      end
    end
    if (b_creset) creset_b++;
    if (s_creset) creset_s++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cur_ready();
    return sel_small ? s_ready : b_ready;
  endfunction

  function automatic logic cur_stall();
    return sel_small ? s_stall : b_stall;
  endfunction

  // Reference model: where the next accepted word should land.
  task automatic model_word(input logic [31:0] d);
    wr_t e;
    if (!sel_small) begin
      if (mw_b <= (1 << AW_B) - 4) begin
        for (int i = 0; i < 4; i++) begin
          e.addr = 16'(mw_b + i);
          e.data = d[8*(3-i) +: 8];
          exp_b.push_back(e);
        end
        mw_b += 4;
      end
    end else begin
      if (mw_s <= (1 << AW_S) - 4) begin
        for (int i = 0; i < 4; i++) begin
          e.addr = 16'(mw_s + i);
          e.data = d[8*(3-i) +: 8];
          exp_s.push_back(e);
        end
        mw_s += 4;
      end
    end
  endtask

  task automatic start_load();
    if (sel_small) mw_s = 0; else mw_b = 0;
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    check("start_stall", 32'(cur_stall()), 32'd1);
    check("start_ready", 32'(cur_ready()), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, output int waited);
    prog_data  = d;
    prog_last  = last;
    prog_valid = 1'b1;
    waited     = 0;
    while (!cur_ready() && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) check("ready_timeout", 32'd1, 32'd0);
    model_word(d);
    tick();
    prog_valid = 1'b0;
    prog_last  = 1'b0;
  endtask

  task automatic wait_run();
    int k = 0;
    while (cur_stall() && k < 50) begin
      tick();
      k++;
    end
    check("run_timeout", 32'(k < 50), 32'd1);
  endtask

  initial begin
    int w;
    int cr0;
    reset = 1'b1; prog_start = 1'b0; prog_valid = 1'b0; prog_last = 1'b0;
    sel_small = 1'b0; prog_data = 32'd0; pc = 32'h10;
    mw_b = 0; mw_s = 0; creset_b = 0; creset_s = 0;
    tick(); tick();
    reset = 1'b0;

    check("rst_addr", 32'(b_addr), 32'h010);
    check("rst_small_addr", 32'(s_addr), 32'h0);
    check("rst_stall", 32'(b_stall), 32'd0);
    check("rst_ready", 32'(b_ready), 32'd0);
    check("rst_we", 32'(b_we), 32'd0);
    check("rst_ovf", 32'(b_ovf), 32'd0);
    check("rst_creset", 32'(b_creset), 32'd0);
    check("rst_words", 32'(b_words), 32'd0);

    // Single-word load
    start_load();
    check("single_waddr", 32'(b_addr), 32'h0);
    send_word(32'h8C64_0000, 1'b1, w);
    check("single_wait", 32'(w), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("single_we", 32'(b_we), 32'd1);
      tick();
    end
    check("flush_creset", 32'(b_creset), 32'd1);
    check("flush_stall", 32'(b_stall), 32'd1);
    check("flush_we", 32'(b_we), 32'd0);
    tick();
    check("post_creset", 32'(b_creset), 32'd0);
    check("post_stall", 32'(b_stall), 32'd0);
    check("post_addr", 32'(b_addr), 32'h010);
    check("single_words", 32'(b_words), 32'd1);
    check("single_pulses", 32'(creset_b), 32'd1);
    check("single_queue", 32'(exp_b.size()), 32'd0);

    // Back-to-back words, started on the first RUN cycle after FLUSH
    start_load();
    send_word(32'h0123_4567, 1'b0, w);
    send_word(32'h89AB_CDEF, 1'b0, w);
    check("b2b_gap2", 32'(w), 32'd4);
    send_word(32'hDEAD_BEEF, 1'b1, w);
    check("b2b_gap3", 32'(w), 32'd4);
    wait_run();
    check("b2b_words", 32'(b_words), 32'd3);
    check("b2b_ovf", 32'(b_ovf), 32'd0);
    check("b2b_pulses", 32'(creset_b), 32'd2);
    check("b2b_queue", 32'(exp_b.size()), 32'd0);

    // Overflow on the 16-byte instance
    sel_small = 1'b1;
    start_load();
    for (int i = 0; i < 5; i++) begin
      send_word(32'hA000_0000 + 32'(i) * 32'h0101_0101, (i == 4), w);
      if (i > 0) check("ovf_gap", 32'(w), 32'd4);
    end
    check("ovf_flush", 32'(s_creset), 32'd1);
    check("ovf_flag", 32'(s_ovf), 32'd1);
    tick();
    check("ovf_run_stall", 32'(s_stall), 32'd0);
    check("ovf_sticky", 32'(s_ovf), 32'd1);
    check("ovf_words", 32'(s_words), 32'd4);
    check("ovf_pulses", 32'(creset_s), 32'd1);
    check("ovf_queue", 32'(exp_s.size()), 32'd0);
    sel_small = 1'b0;

    // Reset in the middle of word 2 (during its bsel=2 byte)
    start_load();
    check("restart_ovf_clear", 32'(b_ovf), 32'd0);
    send_word(32'h1111_2222, 1'b0, w);
    send_word(32'h3344_5566, 1'b1, w);
    tick(); tick();
    check("mid_we", 32'(b_we), 32'd1);
    check("mid_wdata", 32'(b_wdata), 32'h55);
    cr0 = creset_b;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    void'(exp_b.pop_front());
    check("mid_queue", 32'(exp_b.size()), 32'd0);
    check("mid_stall", 32'(b_stall), 32'd0);
    check("mid_we_after", 32'(b_we), 32'd0);
    check("mid_words", 32'(b_words), 32'd0);
    tick(); tick(); tick();
    check("mid_no_pulse", 32'(creset_b), 32'(cr0));

    // prog_start during WRITE must be ignored
    start_load();
    send_word(32'hCAFE_F00D, 1'b0, w);
    tick();
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    send_word(32'h0BAD_F00D, 1'b1, w);
    check("ign_gap", 32'(w), 32'd2);
    wait_run();
    check("ign_words", 32'(b_words), 32'd2);
    check("ign_queue", 32'(exp_b.size()), 32'd0);
    check("ign_small_queue", 32'(exp_s.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
